// File: rtl/ptl_tx_pkg.sv
// Shared types and constants for the PTL transmit arbiter.
package ptl_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Wide enough for hold-off windows up to 15 cycles.
    localparam int HOLD_W = 4;
    localparam int STAT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ptl_rr_pick.sv
// Round-robin picker: first set req bit at or after rr_ptr, wrapping upward.
// Purely combinational; no backpressure of its own.
module ptl_rr_pick
    import ptl_tx_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win,
    output logic            vld
);

    logic [IW:0] pos;

    always_comb begin
        win = '0;
        vld = 1'b0;
        pos = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = {1'b0, rr_ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!vld && req[pos[IW-1:0]]) begin
                win[pos[IW-1:0]] = 1'b1;
                vld              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ptl_tx_arbiter.sv
// Round-robin PTL transmitter scheduler with NRZ edge drive; gnt/tx_q 1 cycle after a pick, done DONE_LAT later.
// Backpressure: refires no sooner than HOLDOFF+1 cycles apart; en low blocks new picks. Stats under PTL_TX_STATS_EN.
module ptl_tx_arbiter
    import ptl_tx_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HOLDOFF  = 4,
    parameter int DONE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              tx_q,
    output logic              busy
`ifdef PTL_TX_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] fire_cnt,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    localparam int IW = idx_w(NREQ);

    state_t              state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       next_ptr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NREQ-1:0]     pick_win;
    logic                pick_vld;
    logic [NREQ-1:0]     done_pipe [DONE_LAT];

    ptl_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win    (pick_win),
        .vld    (pick_vld)
    );

    // gnt holds the latched winner during FIRE, so its index feeds the pointer update.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx = IW'(i);
            end
        end
        next_ptr = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            tx_q     <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (en && pick_vld) begin
                        state <= ST_FIRE;
                        gnt   <= pick_win;
                        tx_q  <= ~tx_q;
                    end
                end
                ST_FIRE: begin
                    rr_ptr   <= next_ptr;
                    hold_cnt <= HOLD_W'(HOLDOFF - 1);
                    state    <= ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end else if (en && pick_vld) begin
                        state <= ST_FIRE;
                        gnt   <= pick_win;
                        tx_q  <= ~tx_q;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DONE_LAT; i++) begin
                done_pipe[i] <= '0;
            end
        end else begin
            done_pipe[0] <= gnt;
            for (int i = 1; i < DONE_LAT; i++) begin
                done_pipe[i] <= done_pipe[i-1];
            end
        end
    end

    assign done = done_pipe[DONE_LAT-1];
    assign busy = (state == ST_FIRE) || (state == ST_HOLDOFF);

`ifdef PTL_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            fire_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == ST_FIRE && fire_cnt != '1) begin
                fire_cnt <= fire_cnt + STAT_W'(1);
            end
            if (state == ST_HOLDOFF && |req && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ptl_tx_arbiter.sv
// Bench for ptl_tx_arbiter: directed scenarios plus random traffic against a timing-rule reference model.
module tb_ptl_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int HOLDOFF  = 4;
    localparam int DONE_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            tx_q;
    logic            busy;
    logic            stat_clr;
`ifdef PTL_TX_STATS_EN
    logic [15:0]     fire_cnt;
    logic [15:0]     stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: fires are allowed once HOLDOFF+1 edges have passed since the last one.
    int              edge_n    = 0;
    int              last_fire = -1000;
    int              ptr       = 0;
    bit              fired     = 0;
    logic            m_txq     = 1'b0;
    logic [NREQ-1:0] m_gnt     = '0;
    logic [NREQ-1:0] m_done    = '0;
    logic            m_busy    = 1'b0;
    logic [NREQ-1:0] ring [16];
    int              m_fire_cnt  = 0;
    int              m_stall_cnt = 0;

    always #5 clk = ~clk;

    ptl_tx_arbiter #(
        .NREQ     (NREQ),
        .HOLDOFF  (HOLDOFF),
        .DONE_LAT (DONE_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .gnt   (gnt),
        .done  (done),
        .tx_q  (tx_q),
        .busy  (busy)
`ifdef PTL_TX_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .fire_cnt  (fire_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic step();
        int w;
        @(posedge clk);
        edge_n++;
        if (!rst_n || stat_clr) begin
            m_fire_cnt  = 0;
            m_stall_cnt = 0;
        end else if (fired) begin
            if (edge_n - 1 == last_fire && m_fire_cnt < 65535) m_fire_cnt++;
            if (edge_n - last_fire >= 2 && edge_n - last_fire <= HOLDOFF + 1 && req != '0 && m_stall_cnt < 65535)
                m_stall_cnt++;
        end
        m_gnt = '0;
        if (!rst_n) begin
            fired  = 0;
            ptr    = 0;
            m_txq  = 1'b0;
            m_done = '0;
            for (int i = 0; i < 16; i++) ring[i] = '0;
        end else begin
            m_done = ring[edge_n % 16];
            ring[edge_n % 16] = '0;
            if (en && req != '0 && (!fired || edge_n - last_fire > HOLDOFF)) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (w < 0 && req[(ptr + i) % NREQ]) w = (ptr + i) % NREQ;
                end
                m_gnt[w] = 1'b1;
                ptr       = (w + 1) % NREQ;
                m_txq     = ~m_txq;
                last_fire = edge_n;
                fired     = 1;
                ring[(edge_n + DONE_LAT) % 16] = m_gnt;
            end
        end
        m_busy = fired && (edge_n - last_fire <= HOLDOFF);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req = '0; stat_clr = 1'b0;
        step();
        step();
        checks++; if (gnt !== '0)   begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (done !== '0)  begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (tx_q !== 1'b0) begin errors++; $display("FAIL reset_tx_q: got %b want 0", tx_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0001; en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if ({gnt, done, tx_q, busy} !== {m_gnt, m_done, m_txq, m_busy}) begin
                errors++;
                $display("FAIL single c%0d: got gnt=%b done=%b tx_q=%b busy=%b want %b %b %b %b", c, gnt, done, tx_q, busy, m_gnt, m_done, m_txq, m_busy);
            end
            if (c == 1) begin
                checks++;
                if (gnt !== 4'b0001 || tx_q !== 1'b1) begin errors++; $display("FAIL single_first_gnt: got gnt=%b tx_q=%b want 0001 1", gnt, tx_q); end
            end
            if (c == 3) begin
                checks++;
                if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", done); end
            end
            if (m_gnt != '0) req = '0;
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] seen [$];
        int              at   [$];
        logic [NREQ-1:0] exp_order [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0; req = '0; step(); rst_n = 1'b1;
        req = 4'b1111; en = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            step();
            checks++;
            if ({gnt, done, tx_q, busy} !== {m_gnt, m_done, m_txq, m_busy}) begin
                errors++;
                $display("FAIL rr c%0d: got gnt=%b done=%b tx_q=%b busy=%b want %b %b %b %b", c, gnt, done, tx_q, busy, m_gnt, m_done, m_txq, m_busy);
            end
            if (gnt != '0) begin seen.push_back(gnt); at.push_back(c); end
        end
        checks++;
        if (seen.size() < 5) begin
            errors++; $display("FAIL rr_count: got %0d grants want at least 5", seen.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (seen[k] !== exp_order[k] || at[k] != 1 + k * (HOLDOFF + 1)) begin
                    errors++;
                    $display("FAIL rr_order #%0d: got gnt=%b at cycle %0d want %b at cycle %0d", k, seen[k], at[k], exp_order[k], 1 + k * (HOLDOFF + 1));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int got = 0;
        rst_n = 1'b0; req = '0; step(); rst_n = 1'b1;
        en = 1'b1; req = 4'b0010;
        step();
        req = '0;
        for (int c = 0; c < 6; c++) step();
        req = 4'b0011;
        for (int c = 0; c < 3 && got == 0; c++) begin
            step();
            if (gnt != '0 || m_gnt != '0) begin
                got = 1;
                checks++;
                if (gnt !== 4'b0001 || m_gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b want 0001", gnt); end
            end
        end
        if (got == 0) begin checks++; errors++; $display("FAIL wrap_timeout: got no grant want 0001"); end
        for (int c = 0; c < HOLDOFF; c++) step();
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_ptr_next: got %b want 0010", gnt); end
        req = '0;
        for (int c = 0; c < 8; c++) step();
    endtask

    task automatic test_en_drop();
        int stray = 0;
        rst_n = 1'b0; req = '0; step(); rst_n = 1'b1;
        req = 4'b1111; en = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL en_first: got %b want 0001", gnt); end
        step();
        en = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if ({gnt, done, tx_q, busy} !== {m_gnt, m_done, m_txq, m_busy}) begin
                errors++;
                $display("FAIL en_off c%0d: got gnt=%b done=%b tx_q=%b busy=%b want %b %b %b %b", c, gnt, done, tx_q, busy, m_gnt, m_done, m_txq, m_busy);
            end
            if (gnt != '0) stray++;
        end
        checks++;
        if (stray != 0 || busy !== 1'b0) begin errors++; $display("FAIL en_idle: got %0d grants busy=%b want 0 grants busy=0", stray, busy); end
        en = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL en_resume: got %b want 0010", gnt); end
        req = '0;
        for (int c = 0; c < 8; c++) step();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; req = '0; step(); rst_n = 1'b1;
        en = 1'b1; req = 4'b0100;
        step();
        req = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (tx_q !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got tx_q=%b busy=%b want 0 0", tx_q, busy); end
        for (int c = 0; c < DONE_LAT + 3; c++) begin
            step();
            checks++;
            if (done !== '0 || m_done !== '0) begin errors++; $display("FAIL rstmid_done c%0d: got %b want 0000", c, done); end
        end
        req = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got %b want 0001", gnt); end
        req = '0;
        for (int c = 0; c < 8; c++) step();
    endtask

    task automatic test_random();
        rst_n = 1'b0; req = '0; step(); rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            en    = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
            checks++;
            if ({gnt, done, tx_q, busy} !== {m_gnt, m_done, m_txq, m_busy}) begin
                errors++;
                $display("FAIL random c%0d: got gnt=%b done=%b tx_q=%b busy=%b want %b %b %b %b", c, gnt, done, tx_q, busy, m_gnt, m_done, m_txq, m_busy);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && m_gnt[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
            end
        end
        rst_n = 1'b1; req = '0;
        for (int c = 0; c < 8; c++) step();
    endtask

`ifdef PTL_TX_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0; req = '0; step(); rst_n = 1'b1;
        req = 4'b1111; en = 1'b1;
        for (int c = 0; c < 21; c++) begin
            step();
            checks++;
            if (fire_cnt !== 16'(m_fire_cnt) || stall_cnt !== 16'(m_stall_cnt)) begin
                errors++;
                $display("FAIL stats c%0d: got fire=%0d stall=%0d want %0d %0d", c, fire_cnt, stall_cnt, m_fire_cnt, m_stall_cnt);
            end
        end
        checks++;
        if (fire_cnt !== 16'd4 || stall_cnt !== 16'd16) begin errors++; $display("FAIL stats_total: got fire=%0d stall=%0d want 4 16", fire_cnt, stall_cnt); end
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        checks++;
        if (fire_cnt !== 16'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL stats_clr: got fire=%0d stall=%0d want 0 0", fire_cnt, stall_cnt); end
        req = '0;
        for (int c = 0; c < 8; c++) step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_en_drop();
        test_reset_mid();
        test_random();
`ifdef PTL_TX_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
